cpu_trace_buffer: RTL and testbench

Synthesizable instruction-trace capture block that sits beside the CPU pipeline, taps the decode-stage instruction/PC/flags, and records them into a parametrised circular buffer. Supports free-running capture and PC-triggered capture with a programmable post-trigger window. Frozen contents are read back one entry at a time and summarised on an 8-bit debug port, replacing simulation-only $display tracing on hardware.

---
 rtl/cpu_trace_buffer_pkg.sv | 33 +++
 rtl/cpu_trace_buffer_classify.sv | 25 ++
 rtl/cpu_trace_buffer.sv | 135 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared encodings for the instruction-trace capture block.
// Holds trace FSM states, instruction classes and ARM opcode field positions.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_CAPT = 2'b01,
    STATE_POST = 2'b10,
    STATE_DONE = 2'b11
  } trace_state_e;

  typedef enum logic [1:0] {
    CLASS_DATA   = 2'b00,
    CLASS_LOAD   = 2'b01,
    CLASS_STORE  = 2'b10,
    CLASS_BRANCH = 2'b11
  } inst_class_e;

  // ARM instruction field positions: op bits 27:25, load/store L bit 20
  localparam int unsigned INST_OP_HI = 27;
  localparam int unsigned INST_OP_LO = 25;
  localparam int unsigned INST_L_BIT = 20;

  localparam int unsigned CLASS_W = 2;
  localparam int unsigned FLAGS_W = 4;
  // class + exec + flags packed above {pc, inst} in each entry
  localparam int unsigned META_W  = CLASS_W + 1 + FLAGS_W;

  function automatic int unsigned entry_width(input int unsigned pc_w, input int unsigned inst_w);
    return pc_w + inst_w + META_W;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_classify.sv
// Combinational ARM instruction classifier: data-processing, load, store, branch.
// Kept standalone so the CPU decoder can reuse it.
module arm_inst_classify
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [1:0]        inst_class_c
);

  logic [2:0] op;

  assign op = inst[INST_OP_HI:INST_OP_LO];

  always_comb begin
    inst_class_c = CLASS_DATA;
    if (op == 3'b101) begin
      inst_class_c = CLASS_BRANCH;
    end else if (op[2:1] == 2'b01) begin
      inst_class_c = inst[INST_L_BIT] ? CLASS_LOAD : CLASS_STORE;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Decode-stage instruction trace buffer with continuous and PC-triggered capture.
// Frozen contents are read back per entry; a status summary is exposed on debug_byte.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned EW    = entry_width(PC_W, INST_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              trace_valid,
  input  logic [INST_W-1:0] trace_inst,
  input  logic [PC_W-1:0]   trace_pc,
  input  logic              trace_exec,
  input  logic [3:0]        trace_flags,
  input  logic              cfg_mode,
  input  logic              cfg_exec_only,
  input  logic [PC_W-1:0]   cfg_trig_pc,
  input  logic [AW:0]       cfg_post,
  input  logic              arm,
  input  logic              stop,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_idx,
  output logic [EW-1:0]     rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [AW:0]       count,
  output logic              triggered,
  output logic              wrapped,
  output logic [7:0]        debug_byte
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  trace_state_e      st;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       post_cnt;
  logic [EW-1:0]     mem [DEPTH];

  logic [1:0]        inst_class;
  logic              capturing;
  logic              accept;
  logic              wr_en;
  logic              trig_hit;
  logic              rd_ok;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     wr_entry;
  logic [3:0]        cnt_sat;

  arm_inst_classify #(
    .INST_W (INST_W)
  ) u_classify (
    .inst         (trace_inst),
    .inst_class_c (inst_class)
  );

  assign capturing = (st == STATE_CAPT) || (st == STATE_POST);
  assign accept    = capturing && trace_valid && (!cfg_exec_only || trace_exec);
  // arm discards the presented entry; stop freezes before it is written
  assign wr_en     = accept && !arm && !stop;
  assign trig_hit  = cfg_mode && (trace_pc == cfg_trig_pc);
  assign rd_ok     = rd_en && !capturing && ({1'b0, rd_idx} < count);
  assign rd_addr   = (wrapped ? wr_ptr : '0) + rd_idx;
  assign wr_entry  = {inst_class, trace_exec, trace_flags, trace_pc, trace_inst};

  // Storage without reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Capture FSM, pointers, status flags and registered read port
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st        <= STATE_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_data  <= rd_ok ? mem[rd_addr] : '0;

      if (arm) begin
        st        <= STATE_CAPT;
        wr_ptr    <= '0;
        count     <= '0;
        post_cnt  <= '0;
        triggered <= 1'b0;
        wrapped   <= 1'b0;
      end else if (stop && capturing) begin
        st <= STATE_DONE;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count == FULL) begin
          wrapped <= 1'b1;
        end else begin
          count <= count + ONE;
        end

        if (st == STATE_CAPT) begin
          if (trig_hit) begin
            triggered <= 1'b1;
            post_cnt  <= cfg_post;
            st        <= (cfg_post == '0) ? STATE_DONE : STATE_POST;
          end
        end else begin
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) begin
            st <= STATE_DONE;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_sat = 4'(count);
    if (32'(count) > 32'd15) begin
      cnt_sat = 4'hF;
    end
  end

  assign state      = st;
  assign debug_byte = {st, triggered, wrapped, cnt_sat};

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer at DEPTH=8.
module tb_cpu_trace_buffer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned AW     = 3;
  localparam int unsigned EW     = PC_W + INST_W + 7;

  logic              clk;
  logic              resetn;
  logic              trace_valid;
  logic [INST_W-1:0] trace_inst;
  logic [PC_W-1:0]   trace_pc;
  logic              trace_exec;
  logic [3:0]        trace_flags;
  logic              cfg_mode;
  logic              cfg_exec_only;
  logic [PC_W-1:0]   cfg_trig_pc;
  logic [AW:0]       cfg_post;
  logic              arm;
  logic              stop;
  logic              rd_en;
  logic [AW-1:0]     rd_idx;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
  logic [1:0]        state;
  logic [AW:0]       count;
  logic              triggered;
  logic              wrapped;
  logic [7:0]        debug_byte;

  int total = 0;
  int bad   = 0;

  cpu_trace_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .trace_valid   (trace_valid),
    .trace_inst    (trace_inst),
    .trace_pc      (trace_pc),
    .trace_exec    (trace_exec),
    .trace_flags   (trace_flags),
    .cfg_mode      (cfg_mode),
    .cfg_exec_only (cfg_exec_only),
    .cfg_trig_pc   (cfg_trig_pc),
    .cfg_post      (cfg_post),
    .arm           (arm),
    .stop          (stop),
    .rd_en         (rd_en),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .state         (state),
    .count         (count),
    .triggered     (triggered),
    .wrapped       (wrapped),
    .debug_byte    (debug_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic ex, input logic [3:0] fl);
    trace_valid = 1'b1;
    trace_pc    = pc;
    trace_inst  = inst;
    trace_exec  = ex;
    trace_flags = fl;
    tick();
    trace_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic do_read(input int idx);
    rd_en  = 1'b1;
    rd_idx = AW'(idx);
    tick();
    rd_en  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; trace_valid = 1'b0; trace_inst = '0; trace_pc = '0;
    trace_exec = 1'b0; trace_flags = '0; cfg_mode = 1'b0; cfg_exec_only = 1'b0;
    cfg_trig_pc = '0; cfg_post = '0; arm = 1'b0; stop = 1'b0; rd_en = 1'b0; rd_idx = '0;

    // reset and idle
    tick(); tick();
    check("rst_state", 128'(state), 128'(2'b00));
    check("rst_count", 128'(count), 128'(0));
    check("rst_debug", 128'(debug_byte), 128'(8'h00));
    check("rst_rdvalid", 128'(rd_valid), 128'(0));
    resetn = 1'b1;
    do_read(0);
    check("idle_rd0_valid", 128'(rd_valid), 128'(0));

    // continuous capture with wrap
    do_arm();
    check("cont_state_capt", 128'(state), 128'(2'b01));
    for (int i = 0; i < 10; i++) push(32'(4 * i), 32'hE3A0_0000 + 32'(i), 1'b1, 4'(i));
    do_stop();
    check("cont_count", 128'(count), 128'(8));
    check("cont_wrapped", 128'(wrapped), 128'(1));
    check("cont_state_done", 128'(state), 128'(2'b11));
    check("cont_debug", 128'(debug_byte), 128'(8'hD8));
    do_read(0);
    check("cont_rd0_valid", 128'(rd_valid), 128'(1));
    check("cont_rd0_data", 128'(rd_data), {57'd0, 2'b00, 1'b1, 4'h2, 32'h0000_0008, 32'hE3A0_0002});
    do_read(7);
    check("cont_rd7_pc", 128'(rd_data[63:32]), 128'(32'd36));

    // PC trigger with post window of 2
    cfg_mode = 1'b1; cfg_trig_pc = 32'h20; cfg_post = 4'd2;
    do_arm();
    for (int i = 0; i < 13; i++) push(32'h10 + 32'(4 * i), 32'hE1A0_0000, 1'b1, 4'h0);
    check("trig_state", 128'(state), 128'(2'b11));
    check("trig_count", 128'(count), 128'(7));
    check("trig_triggered", 128'(triggered), 128'(1));
    check("trig_wrapped", 128'(wrapped), 128'(0));
    check("trig_debug", 128'(debug_byte), 128'(8'hE7));
    do_read(6);
    check("trig_rd6_pc", 128'(rd_data[63:32]), 128'(32'h28));
    do_read(0);
    check("trig_rd0_pc", 128'(rd_data[63:32]), 128'(32'h10));
    do_read(7);
    check("trig_rd7_valid", 128'(rd_valid), 128'(0));
    check("trig_rd7_data", 128'(rd_data), 128'(0));

    // exec-only filter; unexecuted trigger PC must not fire
    cfg_exec_only = 1'b1; cfg_trig_pc = 32'h104; cfg_post = 4'd1;
    do_arm();
    for (int i = 0; i < 6; i++) push(32'h100 + 32'(4 * i), 32'hE1A0_0000, (i % 2) == 0, 4'h5);
    check("exo_state_capt", 128'(state), 128'(2'b01));
    check("exo_triggered", 128'(triggered), 128'(0));
    do_read(0);
    check("exo_capt_rd_valid", 128'(rd_valid), 128'(0));
    check("exo_capt_rd_data", 128'(rd_data), 128'(0));
    do_stop();
    check("exo_count", 128'(count), 128'(3));
    for (int i = 0; i < 3; i++) begin
      do_read(i);
      check("exo_exec_bit", 128'(rd_data[68]), 128'(1));
      check("exo_pc", 128'(rd_data[63:32]), 128'(32'h100 + 32'(8 * i)));
    end

    // class decode
    cfg_exec_only = 1'b0; cfg_mode = 1'b0;
    do_arm();
    push(32'h0, 32'hE3A0_0001, 1'b1, 4'h0);
    push(32'h4, 32'hE591_0000, 1'b1, 4'h0);
    push(32'h8, 32'hE581_0000, 1'b1, 4'h0);
    push(32'hC, 32'hEAFF_FFFE, 1'b1, 4'h0);
    do_stop();
    do_read(0); check("class_data",   128'(rd_data[70:69]), 128'(2'b00));
    do_read(1); check("class_load",   128'(rd_data[70:69]), 128'(2'b01));
    do_read(2); check("class_store",  128'(rd_data[70:69]), 128'(2'b10));
    do_read(3); check("class_branch", 128'(rd_data[70:69]), 128'(2'b11));

    // re-arm during POST discards the arm-cycle entry
    cfg_mode = 1'b1; cfg_trig_pc = 32'h200; cfg_post = 4'd5;
    do_arm();
    push(32'h1F0, 32'hE1A0_0000, 1'b1, 4'h0);
    push(32'h200, 32'hE1A0_0000, 1'b1, 4'h0);
    check("rearm_post_state", 128'(state), 128'(2'b10));
    check("rearm_post_trig", 128'(triggered), 128'(1));
    arm = 1'b1;
    push(32'h204, 32'hE1A0_0000, 1'b1, 4'h0);
    arm = 1'b0;
    check("rearm_count", 128'(count), 128'(0));
    check("rearm_triggered", 128'(triggered), 128'(0));
    check("rearm_state", 128'(state), 128'(2'b01));
    push(32'h300, 32'hE1A0_0000, 1'b1, 4'h0);
    do_stop();
    check("rearm_count1", 128'(count), 128'(1));
    do_read(0);
    check("rearm_rd0_pc", 128'(rd_data[63:32]), 128'(32'h300));
    do_read(1);
    check("rearm_rd1_valid", 128'(rd_valid), 128'(0));

    // synchronous reset during capture, then stop in IDLE is ignored
    do_arm();
    push(32'h400, 32'hE1A0_0000, 1'b1, 4'h0);
    resetn = 1'b0;
    tick();
    check("midrst_state", 128'(state), 128'(2'b00));
    check("midrst_count", 128'(count), 128'(0));
    resetn = 1'b1;
    do_stop();
    check("idle_stop_state", 128'(state), 128'(2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
